// File: rtl/sprite_blitter.sv
// sprite_blitter
// Copies one SPRITE_W x SPRITE_H palette-indexed sprite from its image ROM into the
// full-screen palette-index framebuffer at origin (x0,y0). The blitter moves one pixel
// per cycle. Transparent pixels are skipped. Pixels past the right or bottom screen
// edge are clipped rather than wrapped.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   start     in   request a blit; only looked at while idle
//   x0, y0    in   sprite origin, latched when start is accepted
//   busy      out  high from the cycle after an accepted start until the done pulse
//   done      out  one-cycle pulse when the blit completes
//   src_addr  out  sprite ROM address, row*SPRITE_W+col
//   src_data  in   sprite ROM data, valid one cycle after src_addr
//   fb_addr   out  framebuffer address, x+VIDEO_WIDTH*y
//   fb_data   out  palette index to write
//   fb_wEn    out  framebuffer write enable, one cycle per written pixel
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one sprite ROM address per cycle
// DRAIN | last ROM word returning; final write slot
// DONE  | done pulse, busy already low
module sprite_blitter #(
  parameter int SPRITE_W           = 50,
  parameter int SPRITE_H           = 50,
  parameter int VIDEO_WIDTH        = 640,
  parameter int VIDEO_HEIGHT       = 480,
  parameter int SRC_ADDR_WIDTH     = 13,
  parameter int FB_ADDR_WIDTH      = 20,
  parameter int PALETTE_ADDR_WIDTH = 9,
  parameter int TRANSPARENT_INDEX  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [9:0]                    x0,
  input  logic [8:0]                    y0,
  output logic                          busy,
  output logic                          done,
  output logic [SRC_ADDR_WIDTH-1:0]     src_addr,
  input  logic [PALETTE_ADDR_WIDTH-1:0] src_data,
  output logic [FB_ADDR_WIDTH-1:0]      fb_addr,
  output logic [PALETTE_ADDR_WIDTH-1:0] fb_data,
  output logic                          fb_wEn
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  // One bit wider than the origin ports so that origin+offset never wraps back on screen.
  localparam int PX_W  = 11;
  localparam int PY_W  = 10;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} stateT;

  stateT state, nextState;

  logic [COL_W-1:0]          col, s1Col;
  logic [ROW_W-1:0]          row, s1Row;
  logic [SRC_ADDR_WIDTH-1:0] srcAddr;
  logic [9:0]                xLatch;
  logic [8:0]                yLatch;
  logic                      s1Valid;
  logic                      lastIssue;
  logic                      colWrap;
  logic [PX_W-1:0]           px;
  logic [PY_W-1:0]           py;
  logic [FB_ADDR_WIDTH-1:0]  pixAddr;
  logic                      wrEn;

  assign colWrap   = (col == COL_W'(SPRITE_W - 1));
  assign lastIssue = (state == FETCH) && colWrap && (row == ROW_W'(SPRITE_H - 1));
  assign src_addr  = srcAddr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) nextState = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (lastIssue) nextState = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Address counter runs alongside col/row: row-major order makes it a plain increment.
  // It stops on the last pixel so the ROM is never addressed past the sprite.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      srcAddr <= '0;
      xLatch  <= '0;
      yLatch  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            col     <= '0;
            row     <= '0;
            srcAddr <= '0;
            xLatch  <= x0;
            yLatch  <= y0;
          end
        end
        FETCH: begin
          if (!lastIssue) begin
            srcAddr <= srcAddr + SRC_ADDR_WIDTH'(1);
            if (colWrap) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 1 lines up col/row with the ROM word that returns one cycle after the address.
  assign px      = PX_W'(xLatch) + PX_W'(s1Col);
  assign py      = PY_W'(yLatch) + PY_W'(s1Row);
  assign pixAddr = FB_ADDR_WIDTH'(px) + FB_ADDR_WIDTH'(VIDEO_WIDTH) * FB_ADDR_WIDTH'(py);
  assign wrEn    = s1Valid
                && (src_data != PALETTE_ADDR_WIDTH'(TRANSPARENT_INDEX))
                && (px < PX_W'(VIDEO_WIDTH))
                && (py < PY_W'(VIDEO_HEIGHT));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Col   <= '0;
      s1Row   <= '0;
      fb_wEn  <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      s1Valid <= (state == FETCH);
      s1Col   <= col;
      s1Row   <= row;
      fb_wEn  <= wrEn;
      if (wrEn) begin
        fb_addr <= pixAddr;
        fb_data <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
// Self-checking bench for sprite_blitter. It holds a synchronous sprite ROM. For each
// blit it builds the expected ordered list of framebuffer writes directly from the
// sprite, the origin and the screen size. It then compares every observed write, the
// busy/done timing and the per-scenario totals against that list.
module tb_sprite_blitter;

  localparam int SW = 50;
  localparam int SH = 50;
  localparam int VW = 640;
  localparam int VH = 480;
  localparam int NPIX = SW * SH;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic        busy;
  logic        done;
  logic [12:0] src_addr;
  logic [8:0]  src_data;
  logic [19:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_wEn;

  logic [8:0] rom [0:NPIX-1];

  int checks   = 0;
  int failures = 0;

  sprite_blitter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .busy     (busy),
    .done     (done),
    .src_addr (src_addr),
    .src_data (src_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_wEn   (fb_wEn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (int'(src_addr) < NPIX) src_data <= rom[int'(src_addr)];
    else                       src_data <= '0;
  end

  task automatic checkVal(input string tag, input int obs, input int expd);
    checks++;
    if (obs !== expd) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  // mode 0: constant val, mode 1: addr%4, mode 2: random with about a quarter transparent
  task automatic fillRom(input int mode, input int val);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       rom[i] = 9'(val);
        1:       rom[i] = 9'(i % 4);
        default: rom[i] = ($urandom_range(3) == 0) ? 9'd0 : 9'($urandom_range(255, 1));
      endcase
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic runBlit(input string tag, input int xs, input int ys,
                         input int pokeA, input int pokeB, input int resetAt,
                         input bit doneStart, input int expCount, input int expMax);
    int expAddr[$];
    int expData[$];
    int edges, writes, maxAddr, expSize, px, py, v;
    bit seenDone;

    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        v  = int'(rom[r * SW + c]);
        px = xs + c;
        py = ys + r;
        if (v != 0 && px < VW && py < VH) begin
          expAddr.push_back(px + VW * py);
          expData.push_back(v);
        end
      end
    end
    expSize  = expAddr.size();
    writes   = 0;
    maxAddr  = -1;
    seenDone = 1'b0;
    edges    = 0;

    x0    = 10'(xs);
    y0    = 9'(ys);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (!seenDone && edges < NPIX + 50) begin
      if (fb_wEn) begin
        writes++;
        if (int'(fb_addr) > maxAddr) maxAddr = int'(fb_addr);
        if (expAddr.size() == 0) begin
          checkVal({tag, " extra write"}, writes, expSize);
        end else begin
          checkVal({tag, " fb_addr"}, int'(fb_addr), expAddr.pop_front());
          checkVal({tag, " fb_data"}, int'(fb_data), expData.pop_front());
        end
      end
      checkVal({tag, " busy"}, int'(busy), done ? 0 : 1);
      if (done) begin
        seenDone = 1'b1;
        checkVal({tag, " done cycle"}, edges + 2, NPIX + 3);
        if (doneStart) start = 1'b1;
      end else if (edges == pokeA || edges == pokeB) begin
        start = 1'b1;
        x0    = 10'($urandom_range(1023));
        y0    = 9'($urandom_range(511));
      end else begin
        start = 1'b0;
      end
      if (edges == resetAt) begin
        reset = 1'b1;
        @(posedge clk); #1;
        checkVal({tag, " reset fb_wEn"}, int'(fb_wEn), 0);
        checkVal({tag, " reset busy"}, int'(busy), 0);
        checkVal({tag, " reset done"}, int'(done), 0);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (done || fb_wEn || busy) checkVal({tag, " quiet after reset"}, 1, 0);
        end
        checkVal({tag, " idle after reset"}, int'(busy), 0);
        return;
      end
      if (!seenDone) begin
        @(posedge clk); #1;
        edges++;
      end
    end

    if (!seenDone) checkVal({tag, " done timeout"}, 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    checkVal({tag, " done one cycle"}, int'(done), 0);
    checkVal({tag, " busy after done"}, int'(busy), 0);
    checkVal({tag, " write count"}, writes, expSize);
    if (expCount >= 0) checkVal({tag, " spec write count"}, writes, expCount);
    if (expMax >= 0)   checkVal({tag, " max fb_addr"}, maxAddr, expMax);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x0    = '0;
    y0    = '0;
    fillRom(0, 5);
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset busy", int'(busy), 0);
    checkVal("reset done", int'(done), 0);
    checkVal("reset fb_wEn", int'(fb_wEn), 0);
    checkVal("reset src_addr", int'(src_addr), 0);
    checkVal("reset fb_addr", int'(fb_addr), 0);
    checkVal("reset fb_data", int'(fb_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    runBlit("t1 origin", 0, 0, -1, -1, -1, 1'b0, 2500, 31409);

    fillRom(1, 0);
    runBlit("t2 transparent", 100, 10, -1, -1, -1, 1'b0, 1875, -1);

    fillRom(0, 7);
    runBlit("t3 clip corner", 620, 460, -1, -1, -1, 1'b0, 400, 639 + 640 * 479);

    fillRom(0, 5);
    runBlit("t4 offscreen", 1023, 511, -1, -1, -1, 1'b1, 0, -1);

    fillRom(2, 0);
    runBlit("t5 restart ignored", int'($urandom_range(600)), int'($urandom_range(440)),
            5, 1000, -1, 1'b0, -1, -1);

    runBlit("t6 reset mid", int'($urandom_range(600)), int'($urandom_range(440)),
            -1, -1, 300, 1'b0, -1, -1);
    runBlit("t6 after reset", int'($urandom_range(600)), int'($urandom_range(440)),
            -1, -1, -1, 1'b0, -1, -1);

    for (int n = 0; n < 3; n++) begin
      fillRom(2, 0);
      runBlit("rand", int'($urandom_range(660, 560)), int'($urandom_range(500, 400)),
              -1, -1, -1, 1'b0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
